// File: rtl/max31855_reader.sv
// Periodic/on-demand SPI read controller for a MAX31855 thermocouple converter.
// Shifts in one 32-bit frame per request and presents the decoded fields with a valid strobe.
module max31855_reader #(
  parameter int CLK_DIV     = 4,
  parameter int CS_SETUP    = 8,
  parameter int CS_HOLD     = 4,
  parameter int POLL_PERIOD = 0
) (
  input  logic               i_system_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_so,
  output logic               o_sck,
  output logic               o_cs,
  output logic               o_busy,
  output logic               o_valid,
  output logic        [31:0] o_raw,
  output logic signed [13:0] o_tc_temp,
  output logic signed [11:0] o_int_temp,
  output logic               o_fault,
  output logic        [2:0]  o_fault_bits,
  output logic               o_error
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_SCK_LOW  = 3'd2;
  localparam logic [2:0] S_SCK_HIGH = 3'd3;
  localparam logic [2:0] S_HOLD     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [31:0] POLL_LAST  = 32'(POLL_PERIOD);
  localparam bit          POLL_EN    = (POLL_PERIOD != 0);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [4:0]  bit_cnt;
  logic [31:0] shreg;
  logic [31:0] poll_cnt;
  logic        pending;
  logic        poll_expire;
  logic        req;
  logic        accept;
  logic        sample_en;

  // A frame is inconsistent if a reserved bit is set or the summary fault
  // flag disagrees with the individual fault bits.
  function automatic logic frame_error(input logic [31:0] f);
    return f[17] | f[3] | (f[16] != (|f[2:0]));
  endfunction

  assign poll_expire = POLL_EN && (state == S_IDLE) && (poll_cnt == POLL_LAST);
  assign req         = i_start | poll_expire;
  // The o_valid cycle is a forced gap so cs stays high at least one idle cycle.
  assign accept      = (state == S_IDLE) && !o_valid && (req || pending);
  assign sample_en   = ((state == S_SETUP) && (cnt == SETUP_LAST)) ||
                       ((state == S_SCK_LOW) && (cnt == DIV_LAST) && (bit_cnt != 5'd0));

  always_ff @(posedge i_system_clk) begin
    if (sample_en) begin
      shreg <= {shreg[30:0], i_so};
    end
  end

  always_ff @(posedge i_system_clk) begin
    if (i_reset) begin
      state        <= S_IDLE;
      cnt          <= 16'd0;
      bit_cnt      <= 5'd0;
      poll_cnt     <= 32'd0;
      pending      <= 1'b0;
      o_cs         <= 1'b1;
      o_sck        <= 1'b0;
      o_busy       <= 1'b0;
      o_valid      <= 1'b0;
      o_raw        <= 32'd0;
      o_tc_temp    <= 14'sd0;
      o_int_temp   <= 12'sd0;
      o_fault      <= 1'b0;
      o_fault_bits <= 3'd0;
      o_error      <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if ((state != S_IDLE) && req) begin
        pending <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (POLL_EN && (poll_cnt != POLL_LAST)) begin
            poll_cnt <= poll_cnt + 32'd1;
          end
          if (accept) begin
            state   <= S_SETUP;
            o_cs    <= 1'b0;
            o_busy  <= 1'b1;
            cnt     <= 16'd0;
            pending <= 1'b0;
          end else begin
            o_busy <= 1'b0;
            if (req) begin
              pending <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state   <= S_SCK_HIGH;
            o_sck   <= 1'b1;
            bit_cnt <= 5'd31;
            cnt     <= 16'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SCK_HIGH: begin
          if (cnt == DIV_LAST) begin
            state <= S_SCK_LOW;
            o_sck <= 1'b0;
            cnt   <= 16'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SCK_LOW: begin
          if (cnt == DIV_LAST) begin
            cnt <= 16'd0;
            if (bit_cnt == 5'd0) begin
              state <= S_HOLD;
            end else begin
              bit_cnt <= bit_cnt - 5'd1;
              state   <= S_SCK_HIGH;
              o_sck   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= S_DONE;
            o_cs  <= 1'b1;
            cnt   <= 16'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: begin
          state        <= S_IDLE;
          poll_cnt     <= 32'd0;
          o_valid      <= 1'b1;
          o_raw        <= shreg;
          o_tc_temp    <= shreg[31:18];
          o_int_temp   <= shreg[15:4];
          o_fault      <= shreg[16];
          o_fault_bits <= shreg[2:0];
          o_error      <= frame_error(shreg);
        end
        default: begin
          state <= S_IDLE;
          o_cs  <= 1'b1;
          o_sck <= 1'b0;
        end
      endcase
    end
  end

endmodule
